dm_dma: RTL and testbench



---
 rtl/dm_dma.sv | 121 ++++++++++++
 tb/tb_dm_dma.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dm_dma.sv
// Background block copy / block fill engine driving the word-addressed data memory port.
// | state   | meaning                                          |
// | S_IDLE  | waiting for start; memory address/data hold      |
// | S_READ  | copy: present src_ptr, capture read data         |
// | S_WRITE | present dst_ptr with write enable and write data |
// | S_DONE  | one-cycle completion pulse, then back to idle    |
module dm_dma #(
  parameter int LEN_W = 11
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] length,
  input  logic [31:0]      fill_value,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] words_done,
  output logic [31:0]      mem_address,
  output logic             mem_write,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t           state;
  logic             op_q;
  logic [31:0]      fill_q;
  logic [31:0]      src_ptr;
  logic [31:0]      dst_ptr;
  logic [LEN_W-1:0] count;
  logic [31:0]      src_al;
  logic [31:0]      dst_al;
  logic             unused_addr_bits;

  assign src_al = {src_addr[31:2], 2'b00};
  assign dst_al = {dst_addr[31:2], 2'b00};
  assign unused_addr_bits = ^{src_addr[1:0], dst_addr[1:0]};

  // Outputs are registered one state ahead so they decode purely from flops;
  // mem_wdata doubles as the copy read buffer.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      op_q        <= 1'b0;
      fill_q      <= '0;
      src_ptr     <= '0;
      dst_ptr     <= '0;
      count       <= '0;
      words_done  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_address <= '0;
      mem_write   <= 1'b0;
      mem_wdata   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          busy      <= 1'b0;
          done      <= 1'b0;
          mem_write <= 1'b0;
          if (start) begin
            op_q       <= op;
            fill_q     <= fill_value;
            count      <= length;
            src_ptr    <= src_al;
            dst_ptr    <= dst_al;
            words_done <= '0;
            busy       <= 1'b1;
            if (length == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else if (op) begin
              state       <= S_WRITE;
              mem_address <= dst_al;
              mem_write   <= 1'b1;
              mem_wdata   <= fill_value;
            end else begin
              state       <= S_READ;
              mem_address <= src_al;
            end
          end
        end
        S_READ: begin
          src_ptr     <= src_ptr + 32'd4;
          state       <= S_WRITE;
          mem_address <= dst_ptr;
          mem_write   <= 1'b1;
          mem_wdata   <= mem_rdata;
        end
        S_WRITE: begin
          dst_ptr    <= dst_ptr + 32'd4;
          count      <= count - LEN_W'(1);
          words_done <= words_done + LEN_W'(1);
          if (count == LEN_W'(1)) begin
            state     <= S_DONE;
            mem_write <= 1'b0;
            done      <= 1'b1;
          end else if (op_q) begin
            mem_address <= dst_ptr + 32'd4;
            mem_wdata   <= fill_q;
          end else begin
            state       <= S_READ;
            mem_address <= src_ptr;
            mem_write   <= 1'b0;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_dma.sv
// Self-checking bench for dm_dma: memory model, shadow memory and a write scoreboard.
module tb_dm_dma;
  localparam int LEN_W = 11;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             start;
  logic             op;
  logic [31:0]      src_addr;
  logic [31:0]      dst_addr;
  logic [LEN_W-1:0] length;
  logic [31:0]      fill_value;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] words_done;
  logic [31:0]      mem_address;
  logic             mem_write;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;

  dm_dma #(.LEN_W(LEN_W)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .op(op),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .fill_value(fill_value), .busy(busy), .done(done),
    .words_done(words_done), .mem_address(mem_address),
    .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  logic [31:0] mem [1024];
  logic [31:0] exp_mem [1024];

  assign mem_rdata = mem[mem_address[11:2]];
  always @(posedge clock) if (mem_write) mem[mem_address[11:2]] <= mem_wdata;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;
  wr_t exp_q[$];

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every write the DUT issues must match the head of the queue.
  always @(negedge clock) begin
    if (done) done_cnt++;
    if (mem_write) begin
      chk("wr_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 64'(mem_address), 64'(e.a));
        chk("wr_data", 64'(mem_wdata), 64'(e.d));
      end
    end
  end

  task automatic model_push(input logic o, input logic [31:0] s, input logic [31:0] d,
                            input int n, input logic [31:0] f);
    logic [31:0] sa, da, v;
    wr_t e;
    sa = {s[31:2], 2'b00};
    da = {d[31:2], 2'b00};
    for (int i = 0; i < n; i++) begin
      v = o ? f : exp_mem[sa[11:2]];
      exp_mem[da[11:2]] = v;
      e.a = da;
      e.d = v;
      exp_q.push_back(e);
      sa = sa + 32'd4;
      da = da + 32'd4;
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] v);
    mem[idx] = v;
    exp_mem[idx] = v;
  endtask

  task automatic run_op(input string tag, input logic o, input logic [31:0] s,
                        input logic [31:0] d, input int n, input logic [31:0] f,
                        input int glitch, input int exp_lat);
    int lat, busy_cyc, d0;
    logic seen;
    model_push(o, s, d, n, f);
    d0 = done_cnt;
    lat = 0;
    busy_cyc = 0;
    seen = 1'b0;
    @(negedge clock);
    op = o; src_addr = s; dst_addr = d; length = LEN_W'(n); fill_value = f; start = 1'b1;
    while (!seen && lat < 300) begin
      @(negedge clock);
      start = 1'b0;
      lat++;
      if (busy) busy_cyc++;
      if (done) seen = 1'b1;
      if (glitch != 0 && lat == glitch) begin
        start = 1'b1; op = ~o; src_addr = 32'h0000_0800; dst_addr = 32'h0000_0A00;
        length = LEN_W'(2); fill_value = 32'h5555_AAAA;
      end
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_busy_cyc"}, 64'(busy_cyc), 64'(exp_lat));
    chk({tag, "_words_done"}, 64'(words_done), 64'(n));
    @(negedge clock);
    start = 1'b0;
    chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    chk({tag, "_idle_done"}, 64'(done), 64'd0);
    chk({tag, "_done_once"}, 64'(done_cnt - d0), 64'd1);
    chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_mem(input string tag, input int idx);
    chk(tag, 64'(mem[idx]), 64'(exp_mem[idx]));
  endtask

  initial begin
    int lat, d0;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 32'h0;
      exp_mem[i] = 32'h0;
    end
    reset_n = 1'b0; start = 1'b0; op = 1'b0; src_addr = '0; dst_addr = '0;
    length = '0; fill_value = '0;
    repeat (3) @(negedge clock);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_mem_write", 64'(mem_write), 64'd0);
    chk("rst_mem_address", 64'(mem_address), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_words_done", 64'(words_done), 64'd0);
    reset_n = 1'b1;
    @(negedge clock);

    run_op("fill4", 1'b1, 32'h0, 32'h100, 4, 32'hDEAD_BEEF, 0, 5);
    for (int i = 64; i < 68; i++) chk_mem("fill4_mem", i);

    preload(0, 32'h11); preload(1, 32'h22); preload(2, 32'h33);
    run_op("copy3", 1'b0, 32'h0, 32'h203, 3, 32'h0, 0, 7);
    for (int i = 128; i < 131; i++) chk_mem("copy3_mem", i);
    chk("copy3_mem_abs", 64'(mem[130]), 64'h33);

    run_op("zero", 1'b0, 32'h40, 32'h80, 0, 32'h0, 0, 1);
    run_op("zero_fill", 1'b1, 32'h40, 32'h80, 0, 32'h1, 0, 1);

    run_op("busy_start", 1'b1, 32'h0, 32'h300, 8, 32'hCAFE_0001, 3, 9);
    for (int i = 192; i < 200; i++) chk_mem("busy_start_mem", i);
    chk_mem("busy_start_untouched", 640);

    preload(0, 32'hA); preload(1, 32'hB);
    run_op("overlap", 1'b0, 32'h0, 32'h4, 3, 32'h0, 0, 7);
    for (int i = 1; i < 4; i++) chk("overlap_mem", 64'(mem[i]), 64'hA);

    run_op("wrap", 1'b1, 32'h0, 32'hFFC, 2, 32'h1234_5678, 0, 3);
    chk("wrap_mem1023", 64'(mem[1023]), 64'h1234_5678);
    chk("wrap_mem0", 64'(mem[0]), 64'h1234_5678);

    // Reset during the second WRITE of a 4-word copy (writes occur on cycles 2 and 4).
    for (int i = 0; i < 4; i++) preload(16 + i, 32'hF00 + 32'(i));
    model_push(1'b0, 32'h40, 32'h400, 2, 32'h0);
    d0 = done_cnt;
    @(negedge clock);
    op = 1'b0; src_addr = 32'h40; dst_addr = 32'h400; length = LEN_W'(4); start = 1'b1;
    lat = 0;
    while (lat < 4) begin
      @(negedge clock);
      start = 1'b0;
      lat++;
    end
    chk("rst_mid_wr_present", 64'(mem_write), 64'd1);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_words_done", 64'(words_done), 64'd0);
    repeat (8) @(negedge clock);
    chk("rst_mid_no_done", 64'(done_cnt - d0), 64'd0);
    chk("rst_mid_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("rst_mid_mem1", 64'(mem[257]), 64'hF01);
    chk_mem("rst_mid_mem2", 258);
    chk("rst_mid_mem2_abs", 64'(mem[258]), 64'h0);

    run_op("after_rst", 1'b1, 32'h0, 32'h500, 3, 32'h0BAD_F00D, 0, 4);
    for (int i = 320; i < 323; i++) chk_mem("after_rst_mem", i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
